mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/arb_pkg.sv | 16 +
 rtl/addr_sel_mux2.sv | 17 +
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
//   arbState_e : FSM state encoding (IDLE=0, FETCH=1, DATA=2)
//   ADDR_WIDTH : memory address width
//   DATA_WIDTH : memory data width
package arb_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arbState_e;

endpackage

// File: rtl/addr_sel_mux2.sv
// 2:1 address multiplexer feeding the shared memory address bus.
//   sel  : 0 selects in0 (instruction address), 1 selects in1 (data address)
//   in0  : instruction-side address
//   in1  : data-side address
//   y    : selected address
module addr_sel_mux2
  import arb_pkg::*;
(
  input  logic                  sel,
  input  logic [ADDR_WIDTH-1:0] in0,
  input  logic [ADDR_WIDTH-1:0] in1,
  output logic [ADDR_WIDTH-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between an instruction-fetch requester and
// a data requester. Data normally wins, but after STARVE_MAX consecutive data
// grants with a fetch pending the fetch is forced through. An access that sees
// no mem_ack for MAX_WAIT cycles is aborted and raises a sticky timeout flag.
//   CLK, Reset_n                         : clock, async active-low reset
//   if_req, if_addr                      : fetch request (level) and address
//   if_gnt, if_done, if_rdata            : fetch grant, done pulse, read word
//   dm_req, dm_we, dm_addr, dm_wdata     : data request and command
//   dm_gnt, dm_done, dm_rdata            : data grant, done pulse, read word
//   mem_en, mem_we, mem_addr, mem_wdata  : shared memory command
//   mem_ack, mem_rdata                   : memory completion and read data
//   iord_sel                             : address-mux select (0=fetch, 1=data)
//   timeout                              : sticky access-timeout flag
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_done,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  iord_sel,
  output logic                  timeout
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

  arbState_e             state;
  arbState_e             nextState;
  logic                  armed;       // blocks grants on the first edge after reset release
  logic [STARVE_W-1:0]   starveCnt;
  logic [WAIT_W-1:0]     waitCnt;
  logic                  busy;
  logic                  starved;
  logic                  waitExpired;
  logic                  grantFetch;
  logic                  grantData;
  logic [ADDR_WIDTH-1:0] ifAddrQ;
  logic [ADDR_WIDTH-1:0] dmAddrQ;
  logic                  dmWeQ;
  logic [DATA_WIDTH-1:0] dmWdataQ;
  logic                  iordSelQ;
  logic                  ifDoneQ;
  logic                  dmDoneQ;
  logic [DATA_WIDTH-1:0] ifRdataQ;
  logic [DATA_WIDTH-1:0] dmRdataQ;
  logic                  timeoutQ;

  assign busy        = (state == FETCH) || (state == DATA);
  assign starved     = (starveCnt == STARVE_W'(STARVE_MAX)) && if_req;
  // Expires on the edge that would make this the MAX_WAIT-th ack-less cycle.
  assign waitExpired = busy && !mem_ack && (waitCnt == WAIT_W'(MAX_WAIT - 1));
  assign grantFetch  = (state == IDLE) && (nextState == FETCH);
  assign grantData   = (state == IDLE) && (nextState == DATA);

  // State register.
  // NOTE: state and every other flop use non-blocking assignments so all
  // registers update together from pre-edge values, regardless of block order.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (armed) begin
          if (dm_req && !starved) begin
            nextState = DATA;
          end else if (if_req) begin
            nextState = FETCH;
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ack || waitExpired) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      FETCH: begin
        if_gnt = 1'b1;
        mem_en = 1'b1;
      end
      DATA: begin
        dm_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = dmWeQ;
        mem_wdata = dmWdataQ;
      end
      default: ;
    endcase
  end

  // Command capture, counters, completion and status registers.
  // NOTE: the datapath registers are reset too, because every output they
  // drive (addresses, read words, iord_sel) must read 0 straight out of reset.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      armed     <= 1'b0;
      starveCnt <= '0;
      waitCnt   <= '0;
      ifAddrQ   <= '0;
      dmAddrQ   <= '0;
      dmWeQ     <= 1'b0;
      dmWdataQ  <= '0;
      iordSelQ  <= 1'b0;
      ifDoneQ   <= 1'b0;
      dmDoneQ   <= 1'b0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
      timeoutQ  <= 1'b0;
    end else begin
      armed <= 1'b1;

      // Command is frozen at grant so the requester may change or drop it.
      if (grantFetch) begin
        ifAddrQ  <= if_addr;
        iordSelQ <= 1'b0;
      end
      if (grantData) begin
        dmAddrQ  <= dm_addr;
        dmWeQ    <= dm_we;
        dmWdataQ <= dm_wdata;
        iordSelQ <= 1'b1;
      end

      // Counts data grants that overtook a pending fetch.
      if (!if_req || grantFetch) begin
        starveCnt <= '0;
      end else if (grantData && (starveCnt != STARVE_W'(STARVE_MAX))) begin
        starveCnt <= starveCnt + 1'b1;
      end

      if (busy && !mem_ack) begin
        waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= '0;
      end

      ifDoneQ <= (state == FETCH) && mem_ack;
      dmDoneQ <= (state == DATA) && mem_ack;
      if ((state == FETCH) && mem_ack) begin
        ifRdataQ <= mem_rdata;
      end
      if ((state == DATA) && mem_ack) begin
        dmRdataQ <= mem_rdata;
      end

      if (waitExpired) begin
        timeoutQ <= 1'b1;
      end
    end
  end

  addr_sel_mux2 u_addr_sel_mux2 (
    .sel (iordSelQ),
    .in0 (ifAddrQ),
    .in1 (dmAddrQ),
    .y   (mem_addr)
  );

  assign iord_sel = iordSelQ;
  assign if_done  = ifDoneQ;
  assign dm_done  = dmDoneQ;
  assign if_rdata = ifRdataQ;
  assign dm_rdata = dmRdataQ;
  assign timeout  = timeoutQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset state, fetch read,
// data write with held command, fetch starvation ordering, timeout, ack while
// idle, and reset in the middle of a data access.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        Reset_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_done;
  logic [15:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        iord_sel;
  logic        timeout;

  int nChecks = 0;
  int nFails  = 0;

  mem_port_arbiter #(.STARVE_MAX(3), .MAX_WAIT(15)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .iord_sel  (iord_sel),
    .timeout   (timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_if_gnt"},    16'(if_gnt),    16'd0);
    check({tag, "_dm_gnt"},    16'(dm_gnt),    16'd0);
    check({tag, "_mem_en"},    16'(mem_en),    16'd0);
    check({tag, "_mem_we"},    16'(mem_we),    16'd0);
    check({tag, "_mem_addr"},  mem_addr,       16'h0000);
    check({tag, "_mem_wdata"}, mem_wdata,      16'h0000);
    check({tag, "_iord_sel"},  16'(iord_sel),  16'd0);
    check({tag, "_if_done"},   16'(if_done),   16'd0);
    check({tag, "_dm_done"},   16'(dm_done),   16'd0);
    check({tag, "_if_rdata"},  if_rdata,       16'h0000);
    check({tag, "_dm_rdata"},  dm_rdata,       16'h0000);
    check({tag, "_timeout"},   16'(timeout),   16'd0);
  endtask

  initial begin
    logic [7:0] orderExp;
    int         grants;
    logic       prevAny;
    int         waitBudget;
    int         gntCycles;
    logic       sawDone;

    Reset_n   = 1'b0;
    if_req    = 1'b0;
    if_addr   = 16'h0000;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 16'h0000;
    dm_wdata  = 16'h0000;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;

    // Reset state.
    #2;
    checkAllZero("reset");
    tick();
    tick();

    // Fetch read: release reset with a fetch already pending.
    Reset_n = 1'b1;
    if_req  = 1'b1;
    if_addr = 16'h0010;
    tick();
    check("first_edge_no_grant", 16'(if_gnt), 16'd0);
    tick();
    check("fetch_gnt",      16'(if_gnt),   16'd1);
    check("fetch_dm_gnt",   16'(dm_gnt),   16'd0);
    check("fetch_iord_sel", 16'(iord_sel), 16'd0);
    check("fetch_mem_en",   16'(mem_en),   16'd1);
    check("fetch_mem_we",   16'(mem_we),   16'd0);
    check("fetch_mem_addr", mem_addr,      16'h0010);
    tick();
    check("fetch_wait_gnt",  16'(if_gnt),  16'd1);
    check("fetch_wait_done", 16'(if_done), 16'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    if_req    = 1'b0;
    tick();
    mem_ack = 1'b0;
    check("fetch_done",      16'(if_done),  16'd1);
    check("fetch_rdata",     if_rdata,      16'h1234);
    check("fetch_idle_gnt",  16'(if_gnt),   16'd0);
    check("fetch_idle_en",   16'(mem_en),   16'd0);
    check("fetch_idle_sel",  16'(iord_sel), 16'd0);
    tick();
    check("fetch_done_pulse", 16'(if_done), 16'd0);

    // Data write, ack in the third grant cycle; requester drops and
    // scrambles its command right after the grant.
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 16'h8000;
    dm_wdata  = 16'hBEEF;
    mem_rdata = 16'h5555;
    tick();
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 16'h1111;
    dm_wdata = 16'h0000;
    sawDone  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_gnt_c%0d", i),   16'(dm_gnt),   16'd1);
      check($sformatf("wr_sel_c%0d", i),   16'(iord_sel), 16'd1);
      check($sformatf("wr_we_c%0d", i),    16'(mem_we),   16'd1);
      check($sformatf("wr_addr_c%0d", i),  mem_addr,      16'h8000);
      check($sformatf("wr_wdata_c%0d", i), mem_wdata,     16'hBEEF);
      sawDone |= dm_done;
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    check("wr_early_done", 16'(sawDone),  16'd0);
    check("wr_done",       16'(dm_done),  16'd1);
    check("wr_idle_gnt",   16'(dm_gnt),   16'd0);
    check("wr_idle_en",    16'(mem_en),   16'd0);
    check("wr_idle_sel",   16'(iord_sel), 16'd1);
    tick();
    check("wr_done_pulse", 16'(dm_done),  16'd0);

    // Contention: both requests held, acks always present.
    orderExp = 8'b1110_1110;   // 1 = data grant, first grant in the MSB
    if_req   = 1'b1;
    if_addr  = 16'h0100;
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_addr  = 16'h0200;
    mem_ack  = 1'b1;
    grants   = 0;
    prevAny  = 1'b0;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      tick();
      if (if_gnt || dm_gnt) begin
        check($sformatf("contend_excl_g%0d", grants), 16'(if_gnt && dm_gnt), 16'd0);
        check($sformatf("contend_gap_g%0d", grants),  16'(prevAny),          16'd0);
        check($sformatf("contend_order_g%0d", grants), 16'(dm_gnt), 16'(orderExp[7-grants]));
        grants++;
      end
      prevAny = if_gnt || dm_gnt;
    end
    check("contend_grant_count", 16'(grants), 16'd8);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();

    // Timeout: fetch granted, memory never answers.
    if_req  = 1'b1;
    if_addr = 16'h0ABC;
    waitBudget = 0;
    while (!if_gnt && waitBudget < 5) begin
      tick();
      waitBudget++;
    end
    check("to_granted", 16'(if_gnt), 16'd1);
    gntCycles = 0;
    sawDone   = 1'b0;
    while (if_gnt && gntCycles < 30) begin
      sawDone |= if_done;
      gntCycles++;
      tick();
    end
    sawDone |= if_done;
    check("to_wait_cycles", 16'(gntCycles), 16'd15);
    check("to_flag",        16'(timeout),   16'd1);
    check("to_no_done",     16'(sawDone),   16'd0);
    check("to_idle",        16'(mem_en),    16'd0);
    tick();
    check("to_next_gnt",    16'(if_gnt),    16'd1);
    check("to_next_addr",   mem_addr,       16'h0ABC);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'hCAFE;
    if_req    = 1'b0;
    tick();
    mem_ack = 1'b0;
    check("to_next_done",   16'(if_done),   16'd1);
    check("to_next_rdata",  if_rdata,       16'hCAFE);
    check("to_sticky",      16'(timeout),   16'd1);
    tick();

    // Ack while idle is ignored.
    mem_ack   = 1'b1;
    mem_rdata = 16'h9999;
    tick();
    check("idle_ack_if_done", 16'(if_done), 16'd0);
    check("idle_ack_dm_done", 16'(dm_done), 16'd0);
    check("idle_ack_gnt",     16'(if_gnt || dm_gnt), 16'd0);
    tick();
    mem_ack = 1'b0;
    check("idle_ack_if_done2", 16'(if_done), 16'd0);
    check("idle_ack_dm_done2", 16'(dm_done), 16'd0);
    check("idle_ack_gnt2",     16'(if_gnt || dm_gnt), 16'd0);
    check("idle_ack_if_rdata", if_rdata,     16'hCAFE);
    check("idle_ack_dm_rdata", dm_rdata,     16'h5555);

    // Reset in the middle of a data access.
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 16'h4000;
    dm_wdata = 16'h1357;
    tick();
    check("rst_mid_gnt", 16'(dm_gnt), 16'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    dm_req    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h2468;
    tick();
    Reset_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      sawDone |= dm_done | if_done;
    end
    mem_ack = 1'b0;
    check("rst_mid_no_done", 16'(sawDone), 16'd0);
    check("rst_mid_dm_rdata", dm_rdata,    16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
